// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial subtractor / inverter pair:
// controller states and a constant-evaluable log2 for counter sizing.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/full_add_cell.sv
// Combinational 1-bit full adder; the carry flop lives in the parent.
module full_add_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_sub_inverter.sv
// Bit-serial adder rebuilding minuend A = D + B + bin, LSB first, from the
// serial subtractor's difference; final carry equals the original borrow-out.
module serial_sub_inverter
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] diff,
   input  logic [WIDTH-1:0] sub,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] minuend,
   output logic             bout_rec
);

   localparam int CW = clog2(WIDTH);

   state_e           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_d, r_b, r_minuend;
   logic             r_carry, r_bout;
   logic [CW-1:0]    r_cnt;
   logic             w_s, w_cout, w_last;

   full_add_cell u_fa (
      .a    (r_d[0]),
      .b    (r_b[0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_cout)
   );

   assign w_last = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = SHIFT;
         SHIFT:   if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // r_d doubles as the result register: sum bits enter at the MSB as
   // difference bits leave at the LSB, so after WIDTH shifts it holds A.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_d       <= '0;
         r_b       <= '0;
         r_carry   <= 1'b0;
         r_cnt     <= '0;
         r_minuend <= '0;
         r_bout    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_d     <= diff;
                  r_b     <= sub;
                  r_carry <= bin;
                  r_cnt   <= '0;
               end
            end
            SHIFT: begin
               r_d     <= {w_s, r_d[WIDTH-1:1]};
               r_b     <= {1'b0, r_b[WIDTH-1:1]};
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_minuend <= {w_s, r_d[WIDTH-1:1]};
                  r_bout    <= w_cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = (r_state != IDLE);
   assign done     = (r_state == DONE);
   assign minuend  = r_minuend;
   assign bout_rec = r_bout;

endmodule
